data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width; the array holds 2^ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response, legal range 1..15.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port req_valid  in  1  MEM-stage request present.
REQ-006 Port req_ready  out  1  responder can accept a request this cycle.
REQ-007 Port req_write  in  1  1 means store, 0 means load.
REQ-008 Port req_addr  in  32  byte address, equal to alu_res_EXMEM.
REQ-009 Port req_wdata  in  32  store data, equal to RS2_EXMEM.
REQ-010 Port rsp_valid  out  1  one-cycle response strobe.
REQ-011 Port rsp_rdata  out  32  load data, or echoed store data.
REQ-012 Port rsp_err  out  1  misaligned-access flag.
REQ-013 Port busy  out  1  pipeline stall request.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-016 A request SHALL be accepted on an edge where req_valid && req_ready; accepting it latches req_write, req_addr and req_wdata.
REQ-017 On acceptance, the FSM SHALL go IDLE->RESP if LATENCY==1, otherwise IDLE->WAIT with counter = LATENCY-1.
REQ-018 WAIT SHALL decrement the counter each cycle and go WAIT->RESP on the edge where the counter reaches 1.
REQ-019 rsp_valid SHALL be 1 only in RESP, for exactly one cycle, LATENCY cycles after the accepting edge; RESP->IDLE unconditionally.
REQ-020 A request presented during RESP SHALL NOT be accepted; the earliest next acceptance is the edge after RESP, giving LATENCY+1 cycles minimum per access.
REQ-021 Word index SHALL be latched req_addr[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo 2^ADDR_W words.
REQ-022 A store SHALL commit to the array on the edge entering RESP, and rsp_rdata SHALL equal the stored data.
REQ-023 A load SHALL present array[index] on rsp_rdata during RESP, sampled at the edge entering RESP.
REQ-024 rsp_rdata SHALL hold its last value outside RESP.
REQ-025 busy SHALL be (state != IDLE) || (req_valid && state == IDLE), combinational.
REQ-026 req_valid deasserted in IDLE SHALL leave the FSM in IDLE with no array access.

Reset
REQ-027 Reset SHALL force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready=1 and busy=req_valid then follow combinationally.
REQ-028 Reset SHALL clear all array words to 0.
REQ-029 Reset asserted during WAIT or RESP SHALL abort the access; a store not yet committed SHALL NOT commit.

Configuration
REQ-030 Macro DMEM_MISALIGN_CHECK_EN defined: req_addr[1:0]!=0 on acceptance yields a normal-latency response with rsp_err=1 and rsp_rdata=0, and no store commit.
REQ-031 Macro DMEM_MISALIGN_CHECK_EN undefined: req_addr[1:0] is ignored and rsp_err is tied to 0.

Structure
REQ-032 Package dmem_pkg SHALL hold the state enum, default ADDR_W/LATENCY and the 32-bit word width.
REQ-033 Storage SHALL be a sub-module dmem_array (sync write, registered read, async clear); the FSM stays in data_mem_responder.

Verification
REQ-034 Reset, then load addr 0x10: rsp_valid high exactly 2 cycles after acceptance, rsp_rdata=0, busy high for 3 cycles.
REQ-035 Store 0xDEADBEEF to 0x24, then load 0x24: second response rsp_rdata=0xDEADBEEF; next acceptance no earlier than the edge after RESP.
REQ-036 ADDR_W=8: store 0x11111111 to 0x400, load 0x000 -> 0x11111111 (wrap).
REQ-037 Store to 0x30 with reset pulsed during WAIT, then load 0x30 -> 0, rsp_valid never seen for the aborted request.
REQ-038 Macro defined: store to 0x31 -> rsp_err=1, rsp_rdata=0, load 0x30 -> 0; macro undefined: same store writes word 0x30, rsp_err=0.
REQ-039 LATENCY=1: back-to-back loads held on req_valid -> responses every 2 cycles, req_ready low in each RESP cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state enum, word width and parameter defaults for data_mem_responder
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int LATENCY_DEF = 2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: MEM-stage request/response bus; master is the pipeline, slave the responder
interface data_mem_responder_if;
  logic req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [dmem_pkg::WORD_W-1:0] req_wdata, rsp_rdata;
  logic rsp_valid, rsp_err, busy;
  modport master (output req_valid, req_write, req_addr, req_wdata,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
  modport slave (input req_valid, req_write, req_addr, req_wdata,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with sync write, registered read and async clear
module dmem_array import dmem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic              ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wd,
  output logic [WORD_W-1:0] rd
);
  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rd_q;
  // the read register captures either the array word or the write-side data (store echo / error zero)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
      rd_q <= '0;
    end else begin
      if (we) mem_q[addr] <= wd;
      if (re) rd_q <= ld ? mem_q[addr] : wd;
    end
  assign rd = rd_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data memory responder FSM (IDLE/WAIT/RESP).
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned accesses with rsp_err instead of ignoring addr[1:0].
module data_mem_responder import dmem_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input logic clk,
  input logic reset,
  data_mem_responder_if.slave bus
);
  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              wr_q, err_q, rsp_valid_q, rsp_err_q;
  logic [ADDR_W-1:0] idx_q, cur_idx;
  logic [WORD_W-1:0] wdata_q, cur_wdata;
  logic              idle, go, err_in, cur_wr, cur_err, unused_addr;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign err_in = |bus.req_addr[1:0];
`else
  assign err_in = 1'b0;
`endif
  assign unused_addr = ^bus.req_addr;
  assign idle = state_q == IDLE;
  // go marks the edge entering RESP; with LATENCY==1 that is the accepting edge itself
  assign go = idle ? bus.req_valid && LATENCY == 1 : state_q == WAIT && cnt_q == 4'd1;
  assign cur_wr = idle ? bus.req_write : wr_q;
  assign cur_err = idle ? err_in : err_q;
  assign cur_idx = idle ? bus.req_addr[ADDR_W+1:2] : idx_q;
  assign cur_wdata = idle ? bus.req_wdata : wdata_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= go;
      rsp_err_q   <= go && cur_err;
      case (state_q)
        IDLE: if (bus.req_valid) begin
          wr_q    <= bus.req_write;
          err_q   <= err_in;
          idx_q   <= bus.req_addr[ADDR_W+1:2];
          wdata_q <= bus.req_wdata;
          cnt_q   <= 4'(LATENCY - 1);
          state_q <= LATENCY == 1 ? RESP : WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk  (clk),
    .rst  (reset),
    .re   (go),
    .we   (go && cur_wr && !cur_err),
    .ld   (!cur_wr && !cur_err),
    .addr (cur_idx),
    .wd   (cur_err ? '0 : cur_wdata),
    .rd   (bus.rsp_rdata)
  );
  assign bus.req_ready = idle;
  assign bus.busy      = !idle || bus.req_valid;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (LATENCY=2 and LATENCY=1 instances)
module tb_data_mem_responder;
  import dmem_pkg::*;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [31:0] model [int];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();
  data_mem_responder #(.ADDR_W(8), .LATENCY(2)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  data_mem_responder #(.ADDR_W(8), .LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (bus0.rsp_valid) begin
      exp_t e;
      if (sb.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("rsp_rdata", bus0.rsp_rdata, e.data);
        check("rsp_err", 32'(bus0.rsp_err), 32'(e.err));
        check("rsp_cycle", cyc, e.cyc);
      end
    end

  task automatic check_reset_state();
    check("rst_valid", 32'(bus0.rsp_valid), 32'd0);
    check("rst_rdata", bus0.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus0.rsp_err), 32'd0);
    check("rst_ready", 32'(bus0.req_ready), 32'd1);
    check("rst_busy", 32'(bus0.busy), 32'd0);
  endtask

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int idx;
    logic mis;
    idx = int'((addr >> 2) & 32'hff);
    mis = MIS && (addr[1:0] != 2'b00);
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.req_write = wr;
    bus0.req_addr = addr;
    bus0.req_wdata = wd;
    #1;
    check("ready_idle", 32'(bus0.req_ready), 32'd1);
    check("busy_req", 32'(bus0.busy), 32'd1);
    if (!model.exists(idx)) model[idx] = 32'd0;
    e.err = mis;
    e.data = mis ? 32'd0 : (wr ? wd : model[idx]);
    if (wr && !mis) model[idx] = wd;
    @(posedge clk);
    #1;
    e.cyc = cyc + 1;
    sb.push_back(e);
    bus0.req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("ready_low", 32'(bus0.req_ready), 32'd0);
      check("busy_high", 32'(bus0.busy), 32'd1);
    end
    @(negedge clk);
    check("ready_after", 32'(bus0.req_ready), 32'd1);
    check("busy_after", 32'(bus0.busy), 32'd0);
    check("rsp_missing", sb.size(), 32'd0);
  endtask

  initial begin
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    access(1'b0, 32'h10, 32'd0);
    access(1'b1, 32'h24, 32'hDEADBEEF);
    access(1'b0, 32'h24, 32'd0);
    access(1'b1, 32'h400, 32'h11111111);
    access(1'b0, 32'h000, 32'd0);
    access(1'b1, 32'h3FC, 32'hA5A5_0FF0);
    access(1'b0, 32'hFFFF_FFFC, 32'd0);
    access(1'b1, 32'h31, 32'h77665544);
    access(1'b0, 32'h30, 32'd0);
    for (int i = 0; i < 6; i++)
      access(1'($urandom_range(0, 1)), {22'($urandom), 6'($urandom), 4'h0}, $urandom);
    // store aborted by reset in WAIT must not commit or respond
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h30; bus0.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model.delete();
    @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    access(1'b0, 32'h30, 32'd0);
    access(1'b0, 32'h24, 32'd0);
    // LATENCY=1: one store then loads held on req_valid, a response every second cycle
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 32'h8; bus1.req_wdata = 32'h5A5A0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("l1_valid", 32'(bus1.rsp_valid), 32'(k % 2));
      check("l1_ready", 32'(bus1.req_ready), 32'(1 - k % 2));
      check("l1_busy", 32'(bus1.busy), 32'd1);
      if (k % 2 == 1) check("l1_rdata", bus1.rsp_rdata, 32'h5A5A0001);
      @(posedge clk);
      #1 bus1.req_write = 1'b0;
      @(negedge clk);
    end
    bus1.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
